// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of UartTx: buffers CPU writes and drains them one at a
// time through the UartTx go/bsy handshake, with full/empty/count/overflow status.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_BITWIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [7:0]                wr_data,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH_BITWIDTH:0]   count,
  output logic                      overflow,
  input  logic                      clr_overflow,
  output logic [7:0]                tx_data,
  output logic                      tx_go,
  input  logic                      tx_bsy
);

  localparam int unsigned DEPTH = 2 ** DEPTH_BITWIDTH;
  localparam logic [DEPTH_BITWIDTH:0] FULL_COUNT = (DEPTH_BITWIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    SEND,
    ACK
  } state_t;

  state_t                    state, state_nxt;
  logic [7:0]                mem [DEPTH];
  logic [DEPTH_BITWIDTH-1:0] wr_ptr, rd_ptr;
  logic                      pop, push, drop;
  logic                      go_nxt;
  logic [7:0]                data_nxt;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A push while full is still accepted when the same edge pops: the write
  // lands in the slot being read, and the read sees the old byte.
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tx_go   <= 1'b0;
      tx_data <= '0;
    end else begin
      state   <= state_nxt;
      tx_go   <= go_nxt;
      tx_data <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    go_nxt    = tx_go;
    data_nxt  = tx_data;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        go_nxt = 1'b0;
        if (!empty) begin
          pop       = 1'b1;
          go_nxt    = 1'b1;
          data_nxt  = mem[rd_ptr];
          state_nxt = START;
        end
      end
      START: begin
        go_nxt = 1'b1;
        if (tx_bsy) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        go_nxt = 1'b1;
        if (!tx_bsy) begin
          go_nxt    = 1'b0;
          data_nxt  = '0;
          state_nxt = ACK;
        end
      end
      ACK: begin
        go_nxt    = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        go_nxt    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a vector table for cycle-exact handshakes
// plus hand-written sequences driven against a small UartTx go/bsy model.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       clr_overflow = 1'b0;
  logic       full, empty, overflow, tx_go;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       tx_bsy;

  logic       model_en = 1'b0;
  logic       man_bsy = 1'b0;
  logic       m_bsy = 1'b0;
  logic       m_busy = 1'b0;
  logic       m_wait = 1'b0;
  logic       m_stall = 1'b0;
  int         m_len = 2;
  int         m_cnt = 0;
  logic [7:0] rx_q[$];

  int n_cmp = 0;
  int n_err = 0;

  assign tx_bsy = model_en ? m_bsy : man_bsy;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH_BITWIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .tx_data      (tx_data),
    .tx_go        (tx_go),
    .tx_bsy       (tx_bsy)
  );

  // UartTx model: latch on go, stay busy m_len+1 cycles, then wait for go low.
  always @(negedge clk) begin
    if (!rst) begin
      m_bsy  = 1'b0;
      m_busy = 1'b0;
      m_wait = 1'b0;
    end else if (model_en) begin
      if (m_busy) begin
        if (!m_stall) begin
          if (m_cnt == 0) begin
            m_bsy  = 1'b0;
            m_busy = 1'b0;
            m_wait = 1'b1;
          end else begin
            m_cnt = m_cnt - 1;
          end
        end
      end else if (m_wait) begin
        if (!tx_go) m_wait = 1'b0;
      end else if (tx_go) begin
        rx_q.push_back(tx_data);
        m_bsy  = 1'b1;
        m_busy = 1'b1;
        m_cnt  = m_len;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_rx(input string name, input int n, input int limit);
    for (int k = 0; k < limit && rx_q.size() < n; k++) @(posedge clk);
    chk(name, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic push_byte(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       bsy;
    logic [4:0] cnt;
    logic       go;
    logic [7:0] txd;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  initial begin
    int base;
    int bad;
    logic seen, fell;

    // wr, data, bsy  -> count, go, tx_data after the edge
    tbl[0]  = '{1'b1, 8'h41, 1'b0, 5'd1, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 8'h41};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 8'h41};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'h41};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'h41};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00};
    tbl[9]  = '{1'b1, 8'h55, 1'b0, 5'd1, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 8'h66, 1'b0, 5'd1, 1'b1, 8'h55};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'h55};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 8'h00};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 8'h00};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 8'h66};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'h66};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00};

    // Reset state, held and after release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_go", 32'(tx_go), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_empty", 32'(empty), 32'd1);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_go", 32'(tx_go), 32'd0);
    chk("idle_ovf", 32'(overflow), 32'd0);

    // Cycle-exact handshake table with manually driven bsy
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      wr_en   = tbl[i].wr;
      wr_data = tbl[i].d;
      man_bsy = tbl[i].bsy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].cnt == 0));
      chk($sformatf("vec%0d_go", i), 32'(tx_go), 32'(tbl[i].go));
      chk($sformatf("vec%0d_txd", i), 32'(tx_data), 32'(tbl[i].txd));
    end
    @(negedge clk);
    wr_en   = 1'b0;
    man_bsy = 1'b0;

    // Single byte through the model, 20-cycle busy
    @(posedge clk);
    #1;
    model_en = 1'b1;
    m_len    = 19;
    base     = rx_q.size();
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'h41;
    @(posedge clk);
    #1;
    chk("t2_go_push_edge", 32'(tx_go), 32'd0);
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    chk("t2_go_pop_edge", 32'(tx_go), 32'd1);
    chk("t2_txd", 32'(tx_data), 32'h41);
    bad  = 0;
    seen = 1'b0;
    fell = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (tx_bsy) begin
        seen = 1'b1;
        if (!tx_go) bad++;
      end else if (seen) begin
        fell = 1'b1;
        break;
      end
    end
    chk("t2_bsy_fell", 32'(fell), 32'd1);
    chk("t2_go_low_while_bsy", 32'(bad), 32'd0);
    chk("t2_go_fall", 32'(tx_go), 32'd0);
    chk("t2_count", 32'(count), 32'd0);
    chk("t2_rx_size", 32'(rx_q.size()), 32'(base + 1));
    chk("t2_rx_byte", 32'(rx_q[base]), 32'h41);

    // Ordering across pointer wrap, pushes paced slower than drain
    repeat (5) @(posedge clk);
    m_len = 3;
    base  = rx_q.size();
    for (int i = 0; i < 40; i++) begin
      push_byte(8'(i));
      repeat (12) @(negedge clk);
    end
    wait_rx("t3_timeout", base + 40, 500);
    for (int i = 0; i < 40; i++) begin
      if (base + i < rx_q.size()) chk($sformatf("t3_rx%0d", i), 32'(rx_q[base + i]), 32'(i));
    end
    chk("t3_ovf", 32'(overflow), 32'd0);

    // Overflow with the transmitter stalled
    repeat (20) @(posedge clk);
    m_stall = 1'b1;
    m_len   = 2;
    base    = rx_q.size();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'h10 + 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    chk("t4_txd", 32'(tx_data), 32'h10);
    chk("t4_count", 32'(count), 32'd16);
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_ovf", 32'(overflow), 32'd1);
    @(negedge clk);
    wr_en        = 1'b1;
    wr_data      = 8'h99;
    clr_overflow = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_set_beats_clr", 32'(overflow), 32'd1);
    chk("t4_count_hold", 32'(count), 32'd16);
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    chk("t4_clr", 32'(overflow), 32'd0);
    @(negedge clk);
    clr_overflow = 1'b0;
    m_stall      = 1'b0;
    wait_rx("t4_timeout", base + 17, 1000);
    repeat (30) @(posedge clk);
    #1;
    chk("t4_rx_size", 32'(rx_q.size()), 32'(base + 17));
    for (int i = 0; i < 17; i++) begin
      if (base + i < rx_q.size()) chk($sformatf("t4_rx%0d", i), 32'(rx_q[base + i]), 32'(8'h10 + 8'(i)));
    end
    chk("t4_empty", 32'(empty), 32'd1);

    // Push on the pop edge while full
    model_en = 1'b0;
    man_bsy  = 1'b0;
    push_byte(8'hA0);
    @(negedge clk);
    man_bsy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'hB0 + 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_full_before", 32'(full), 32'd1);
    @(negedge clk);
    man_bsy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    @(posedge clk);
    #1;
    chk("t5_count", 32'(count), 32'd16);
    chk("t5_full", 32'(full), 32'd1);
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_go", 32'(tx_go), 32'd1);
    chk("t5_txd", 32'(tx_data), 32'hB0);
    base     = rx_q.size();
    model_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    wait_rx("t5_timeout", base + 17, 1500);
    for (int i = 0; i < 17; i++) begin
      if (base + i < rx_q.size())
        chk($sformatf("t5_rx%0d", i), 32'(rx_q[base + i]), (i < 16) ? 32'(8'hB0 + 8'(i)) : 32'hEE);
    end

    // Reset while sending with 5 queued
    repeat (20) @(posedge clk);
    m_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'hC0 + 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_go_sending", 32'(tx_go), 32'd1);
    chk("t6_count_before", 32'(count), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_go_async", 32'(tx_go), 32'd0);
    chk("t6_count_async", 32'(count), 32'd0);
    chk("t6_empty_async", 32'(empty), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b1;
    m_stall = 1'b0;
    base    = rx_q.size();
    bad     = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (tx_go) bad++;
    end
    chk("t6_no_resend", 32'(bad), 32'd0);
    push_byte(8'h77);
    wait_rx("t6_timeout", base + 1, 200);
    if (base < rx_q.size()) chk("t6_rx_new", 32'(rx_q[base]), 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
